// File: rtl/mu0_run_controller.sv
// MU0 run sequencer: reset hold, run/timeout control and write-trace FIFO.
// Optional breakpoint compare on BusAddr: define MU0_RUN_BREAKPOINT_EN.
module mu0_run_controller #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int RESET_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 110,
    parameter int TRACE_DEPTH    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    output logic                  CpuReset,
    input  logic                  CpuHalted,
    input  logic                  BusWr,
    input  logic [ADDR_WIDTH-1:0] BusAddr,
    input  logic [DATA_WIDTH-1:0] BusDout,
    output logic                  Running,
    output logic                  Done,
    output logic [1:0]            Status,
    output logic [CNT_WIDTH-1:0]  CycleCount,
    output logic                  TraceValid,
    input  logic                  TraceReady,
    output logic [ADDR_WIDTH-1:0] TraceAddr,
    output logic [DATA_WIDTH-1:0] TraceData,
    output logic                  TraceOverflow
`ifdef MU0_RUN_BREAKPOINT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] BpAddr
`endif
);

    localparam int PW  = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam int EW  = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [RCW-1:0]       RST_LOAD = RCW'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(TRACE_DEPTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
`ifdef MU0_RUN_BREAKPOINT_EN
    localparam logic [1:0] ST_BREAK   = 2'b11;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [RCW-1:0] rst_cnt;

    logic           start_ok;
    logic           run_exit;
    logic [1:0]     exit_code;

    logic           push;
    logic           pop;
    logic           full;
    logic           do_push;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_next;
    logic [CW-1:0]  fifo_cnt;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  mem [TRACE_DEPTH];

    // Start only counts when the sequencer is parked.
    assign start_ok = Start && (state == S_IDLE || state == S_DONE);

    // RUN exit decision, halt first, then breakpoint, then timeout.
    always_comb begin
        run_exit  = 1'b1;
        exit_code = ST_NONE;
        if (CpuHalted) begin
            exit_code = ST_HALTED;
`ifdef MU0_RUN_BREAKPOINT_EN
        end else if (BusAddr == BpAddr) begin
            exit_code = ST_BREAK;
`endif
        end else if (CycleCount == CNT_LAST) begin
            exit_code = ST_TIMEOUT;
        end else begin
            run_exit = 1'b0;
        end
    end

    // Sequencer FSM with registered CPU control and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            CpuReset   <= 1'b1;
            Running    <= 1'b0;
            Done       <= 1'b0;
            Status     <= ST_NONE;
            CycleCount <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state      <= S_RESET;
                        rst_cnt    <= RST_LOAD;
                        CpuReset   <= 1'b1;
                        Done       <= 1'b0;
                        Status     <= ST_NONE;
                        CycleCount <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == '0) begin
                        state    <= S_RUN;
                        CpuReset <= 1'b0;
                        Running  <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RCW'(1);
                    end
                end
                S_RUN: begin
                    if (run_exit) begin
                        state    <= S_DONE;
                        CpuReset <= 1'b1;
                        Running  <= 1'b0;
                        Done     <= 1'b1;
                        Status   <= exit_code;
                    end else begin
                        CycleCount <= CycleCount + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    CpuReset <= 1'b1;
                    Running  <= 1'b0;
                    Done     <= 1'b0;
                end
            endcase
        end
    end

    assign push       = (state == S_RUN) && BusWr;
    assign pop        = TraceValid && TraceReady;
    assign full       = (fifo_cnt == CNT_FULL);
    assign do_push    = push && (!full || pop);
    assign rd_next    = rd_ptr + PW'(1);
    assign wr_entry   = {BusAddr, BusDout};
    assign TraceValid = (fifo_cnt != '0);

    // Trace storage; contents need no reset since the count gates them.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers, occupancy, overflow flag and registered head entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            TraceOverflow <= 1'b0;
            TraceAddr     <= '0;
            TraceData     <= '0;
        end else if (start_ok) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            TraceOverflow <= 1'b0;
            TraceAddr     <= '0;
            TraceData     <= '0;
        end else begin
            if (push && full && !pop) begin
                TraceOverflow <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (pop && fifo_cnt != CNT_ONE) begin
                {TraceAddr, TraceData} <= mem[rd_next];
            end else if (do_push &&
                         (fifo_cnt == '0 || (pop && fifo_cnt == CNT_ONE))) begin
                {TraceAddr, TraceData} <= wr_entry;
            end
        end
    end

endmodule
